ser_tx: RTL
===========

# ser_tx

Parallel-in, serial-out frame transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on a single line, LSB first, framed by a start bit (0) and a stop bit (1). Each bit is held for DIV clock cycles. It sits after the enabled data registers and drives the project's serial output pin; it is the transmit end of the same link that the capture registers receive from.

## Interface
- WIDTH, 4: data bits per frame; must be ≥ 1.
- DIV, 4: clock cycles per serial bit; must be ≥ 1. DIV=1 must be supported.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to transmit; sampled only on the acceptance edge.
- in_ready  output  1  block can accept a word; registered.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  a frame is in progress (START, DATA or STOP); registered.
- done  output  1  one-cycle pulse when a frame completes; registered.

## Operation
- Reset is synchronous: on any rising edge with rst_n=0, the block loads its reset state.
  - Reset state: IDLE, tx=1, in_ready=0, busy=0, done=0, counters and shift register 0.
  - On the first edge with rst_n=1 from IDLE, in_ready becomes 1.
  - Reset dominates: no word is accepted on an edge where rst_n=0.
- State machine states: IDLE, START, DATA, STOP.
- Acceptance:
  - An accept happens on an edge where in_valid=1, in_ready=1 and rst_n=1.
  - On the accept edge: shift register ← in_data, state → START, tx → 0, in_ready → 0, busy → 1, bit-timer → 0.
  - Changes to in_data after the accept edge have no effect on the frame.
  - in_valid while in_ready=0 is ignored; it is not queued.
- Bit-timer: counts 0..DIV-1, sized max(1, $clog2(DIV)). A bit ends on the edge where the timer equals DIV-1; the timer then wraps to 0.
- START → DATA at the end of the start bit: tx ← shift register bit 0.
- DATA:
  - At the end of each data bit, the shift register shifts right and tx ← the new bit 0.
  - A bit index counts 0..WIDTH-1, sized max(1, $clog2(WIDTH)).
  - At the end of bit WIDTH-1: state → STOP, tx → 1.
- STOP → IDLE at the end of the stop bit: tx=1, busy → 0, in_ready → 1, done → 1 for exactly that one cycle.
- In IDLE, tx=1 and done=0 every cycle except the completion cycle.
- Reset mid-frame (any state): the frame is abandoned. The block enters the reset state with tx=1 on that edge, and no done pulse is produced.

## Timing
- Let E0 be the accept edge. Total frame length is (WIDTH+2)*DIV cycles.
- Start bit: tx=0 from E0 up to E0+DIV.
- Data bit k (k = 0..WIDTH-1): tx=in_data[k] from E0+(k+1)*DIV up to E0+(k+2)*DIV.
- Stop bit: tx=1 from E0+(WIDTH+1)*DIV.
- Completion edge Ec = E0+(WIDTH+2)*DIV. After Ec, the block is IDLE with in_ready=1 and done=1; done drops at Ec+1.
- Back-to-back: if in_valid is held high, the next accept edge is Ec+1. The line therefore sees the stop bit plus exactly 1 extra idle-high cycle between frames.
- Input-to-output latency: tx reflects the start bit on the accept edge itself, so 0 cycles after acceptance.
- busy=1 exactly from E0 through Ec-1, i.e. (WIDTH+2)*DIV cycles.

## Test plan
- **Reset release:** hold rst_n=0 for 3 cycles with in_valid=1, then release.
  - While rst_n=0: tx=1, in_ready=0, busy=0, done=0, and no frame starts.
  - First edge with rst_n=1: in_ready=1.
  - Second edge: accept.
- **Single frame, WIDTH=4, DIV=4, in_data=4'hA:**
  - tx reads 0,0,1,0,1,1, each held 4 cycles.
  - done is high for exactly 1 cycle, 24 cycles after the accept edge.
  - busy is high for 24 cycles.
- **Back-to-back, in_valid held high, data 4'h3 then 4'hC, DIV=4:**
  - Second accept occurs 25 cycles after the first.
  - tx sequence: 0,1,1,0,0,1 followed by 1 idle cycle, then 0,0,0,1,1,1 (bits ×4 cycles).
  - done pulses twice.
- **DIV=1, WIDTH=4, in_data=4'h5:**
  - tx reads 0,1,0,1,0,1 on consecutive cycles.
  - done is high 6 cycles after the accept edge.
- **Mid-frame reset:** DIV=4, in_data=4'hF, assert rst_n=0 for 1 edge during data bit 1.
  - tx=1 on that edge and the frame is aborted.
  - No done pulse.
  - in_ready=1 one edge after rst_n returns high.
- **Input stability:** change in_data every cycle after acceptance of 4'h6, and pulse in_valid while busy.
  - tx carries 0,0,1,1,0,1.
  - No second frame starts until in_ready=1 and in_valid=1 on the same edge.

Source files
------------

// File: rtl/ser_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits LSB first,
// stop bit (1), each bit held for DIV clock cycles.
module ser_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [TW-1:0]    timer_reg;
    logic [IW-1:0]    idx_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             tx_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             bit_end;

    // Right shift with zero fill; the vacated MSB is never transmitted.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shift_next[gi] = 1'b0;
            end else begin : g_mid
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign bit_end = (timer_reg == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg       <= 1'b1;
                    in_ready_reg <= 1'b1;
                    // in_ready_reg gates acceptance so the first post-reset edge only raises ready.
                    if (in_valid && in_ready_reg) begin
                        shift_reg    <= in_data;
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        timer_reg    <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer_reg <= '0;
                        idx_reg   <= '0;
                        state_reg <= DATA;
                        tx_reg    <= shift_reg[0];
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_reg <= '0;
                        if (idx_reg == IW'(WIDTH - 1)) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            shift_reg <= shift_next;
                            tx_reg    <= shift_next[0];
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer_reg    <= '0;
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        in_ready_reg <= 1'b1;
                        done_reg     <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_reg;
    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
